// File: rtl/rv32_mem_interconnect.sv
// Data-side interconnect: decodes core requests to NSLAVES fixed-latency slaves and returns
// tagged responses. Optional sticky fault-address capture is built when MEM_ERR_LATCH_EN is defined.
module rv32_mem_interconnect #(
  parameter int unsigned               XLEN       = 32,
  parameter int unsigned               NSLAVES    = 4,
  parameter logic [NSLAVES*XLEN-1:0]   SLV_BASE   = '0,
  parameter logic [NSLAVES*XLEN-1:0]   SLV_MASK   = '0,
  parameter logic [NSLAVES-1:0]        SLV_RO     = '0,
  parameter int unsigned               RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [XLEN-1:0]           mem_addr,
  input  logic [XLEN/8-1:0]         mem_byteen,
  input  logic [XLEN-1:0]           mem_wdata,
  output logic                      mem_rvalid,
  output logic [XLEN-1:0]           mem_rdata,
  output logic                      mem_err,
  output logic [NSLAVES-1:0]        s_req,
  output logic                      s_we,
  output logic [XLEN-1:0]           s_addr,
  output logic [XLEN/8-1:0]         s_byteen,
  output logic [XLEN-1:0]           s_wdata,
  input  logic [NSLAVES*XLEN-1:0]   s_rdata
`ifdef MEM_ERR_LATCH_EN
  ,
  output logic [XLEN-1:0]           err_addr,
  output logic                      err_valid,
  input  logic                      err_clr
`endif
);

  localparam int unsigned IdxW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int unsigned Last = RD_LATENCY - 1;

  logic            hit;
  logic [IdxW-1:0] sel_idx;
  logic            sel_ro;
  logic            req_err;
  logic            accept;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    sel_ro  = 1'b0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        hit     = 1'b1;
        sel_idx = IdxW'(i);
        sel_ro  = SLV_RO[i];
      end
    end
  end

  assign req_err = ~hit | (mem_addr[1:0] != 2'b00) | (mem_byteen == '0) | (mem_we & sel_ro);
  assign accept  = mem_req & ~req_err & ~rst;

  always_comb begin
    s_req = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (accept && (sel_idx == IdxW'(i))) begin
        s_req[i] = 1'b1;
      end
    end
  end

  assign s_we     = mem_we;
  assign s_addr   = mem_addr;
  assign s_byteen = mem_byteen;
  assign s_wdata  = mem_wdata;

  // Response pipeline: one entry per cycle, so ordering and back-to-back timing come for free.
  logic            v_q   [RD_LATENCY];
  logic [IdxW-1:0] idx_q [RD_LATENCY];
  logic            err_q [RD_LATENCY];
  logic            we_q  [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        v_q[k]   <= 1'b0;
        idx_q[k] <= '0;
        err_q[k] <= 1'b0;
        we_q[k]  <= 1'b0;
      end
    end else begin
      v_q[0]   <= mem_req;
      idx_q[0] <= sel_idx;
      err_q[0] <= mem_req & req_err;
      we_q[0]  <= mem_req & mem_we;
      for (int k = 1; k < RD_LATENCY; k++) begin
        v_q[k]   <= v_q[k-1];
        idx_q[k] <= idx_q[k-1];
        err_q[k] <= err_q[k-1];
        we_q[k]  <= we_q[k-1];
      end
    end
  end

  logic [XLEN-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (idx_q[Last] == IdxW'(i)) begin
        rd_sel = s_rdata[i*XLEN +: XLEN];
      end
    end
  end

  // Reset gates the outputs directly so a response in flight never escapes during rst.
  assign mem_rvalid = v_q[Last] & ~rst;
  assign mem_err    = v_q[Last] & err_q[Last] & ~rst;
  assign mem_rdata  = (mem_rvalid & ~err_q[Last] & ~we_q[Last]) ? rd_sel : '0;

`ifdef MEM_ERR_LATCH_EN
  logic [XLEN-1:0] addr_q [RD_LATENCY];
  logic [XLEN-1:0] err_addr_q, err_addr_d;
  logic            err_valid_q, err_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        addr_q[k] <= '0;
      end
    end else begin
      addr_q[0] <= mem_addr;
      for (int k = 1; k < RD_LATENCY; k++) begin
        addr_q[k] <= addr_q[k-1];
      end
    end
  end

  // A fresh error beats a simultaneous clear.
  always_comb begin
    err_addr_d  = err_addr_q;
    err_valid_d = err_valid_q;
    if (mem_err && (!err_valid_q || err_clr)) begin
      err_addr_d  = addr_q[Last];
      err_valid_d = 1'b1;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_valid = err_valid_q;
`endif

endmodule

// File: tb/tb_rv32_mem_interconnect.sv
// Bench for rv32_mem_interconnect: two slaves (RAM, read-only ROM), latency 1.
// Queue-based response model plus hand-computed literal expectations.
module tb_rv32_mem_interconnect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [3:0]  mem_byteen = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [1:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [3:0]  s_byteen;
  logic [31:0] s_wdata;
  logic [63:0] s_rdata;
`ifdef MEM_ERR_LATCH_EN
  logic [31:0] err_addr;
  logic        err_valid;
  logic        err_clr = 1'b0;
`endif

  rv32_mem_interconnect #(
    .XLEN       (32),
    .NSLAVES    (2),
    .SLV_BASE   (64'h1000_0000_0000_0000),
    .SLV_MASK   (64'hFFFC_0000_FFFE_0000),
    .SLV_RO     (2'b10),
    .RD_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .s_req      (s_req),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_byteen   (s_byteen),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata)
`ifdef MEM_ERR_LATCH_EN
    ,
    .err_addr   (err_addr),
    .err_valid  (err_valid),
    .err_clr    (err_clr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory map as plain tables.
  logic [31:0] m_base [2] = '{32'h0000_0000, 32'h1000_0000};
  logic [31:0] m_mask [2] = '{32'hFFFE_0000, 32'hFFFC_0000};
  bit          m_ro   [2] = '{1'b0, 1'b1};

  function automatic logic [31:0] pat(input int i, input logic [31:0] a);
    return (i == 0 ? 32'hA5A5_0000 : 32'h5A5A_0000) ^ a;
  endfunction

  function automatic int m_slave(input logic [31:0] a);
    for (int i = 0; i < 2; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_err(input logic we, input logic [31:0] a, input logic [3:0] be);
    int s;
    s = m_slave(a);
    if (s < 0) return 1'b1;
    if (a[1:0] != 2'b00) return 1'b1;
    if (be == 4'h0) return 1'b1;
    if (we && m_ro[s]) return 1'b1;
    return 1'b0;
  endfunction

  // Slaves: latency-1 data derived from address; garbage when not selected.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      s_rdata[i*32 +: 32] <= s_req[i] ? pat(i, s_addr) : (32'hDEAD_BEE0 | 32'(i));
    end
  end

  typedef struct {
    bit          v;
    bit          e;
    logic [31:0] d;
    logic [31:0] a;
  } resp_t;

  resp_t exp_q[$];
`ifdef MEM_ERR_LATCH_EN
  bit          m_ev = 1'b0;
  logic [31:0] m_ea = 32'h0;
`endif

  // Model: each accepted cycle's request becomes the response shown next cycle.
  always @(posedge clk) begin
    resp_t n;
    n = '{v: 1'b0, e: 1'b0, d: 32'h0, a: 32'h0};
`ifdef MEM_ERR_LATCH_EN
    if (rst) begin
      m_ev = 1'b0;
      m_ea = 32'h0;
    end else if (exp_q.size() > 0 && exp_q[0].v && exp_q[0].e && (!m_ev || err_clr)) begin
      m_ev = 1'b1;
      m_ea = exp_q[0].a;
    end else if (err_clr) begin
      m_ev = 1'b0;
    end
`endif
    if (!rst && mem_req) begin
      n.v = 1'b1;
      n.e = m_err(mem_we, mem_addr, mem_byteen);
      n.a = mem_addr;
      n.d = (n.e || mem_we) ? 32'h0 : pat(m_slave(mem_addr), mem_addr);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_q.push_back(n);
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    resp_t       e;
    logic [1:0]  es;
    int          s;
    if (ready) begin
      e = exp_q[0];
      if (rst) e.v = 1'b0;
      chk("cmp_rvalid", 32'(mem_rvalid), 32'(e.v));
      chk("cmp_err", 32'(mem_err), 32'(e.v && e.e));
      chk("cmp_rdata", mem_rdata, e.v ? e.d : 32'h0);
      s  = m_slave(mem_addr);
      es = 2'b00;
      if (mem_req && !rst && !m_err(mem_we, mem_addr, mem_byteen)) es = (s == 0) ? 2'b01 : 2'b10;
      chk("cmp_sreq", 32'(s_req), 32'(es));
      chk("cmp_saddr", s_addr, mem_addr);
      chk("cmp_swdata", s_wdata, mem_wdata);
      chk("cmp_sctl", {27'h0, s_we, s_byteen}, {27'h0, mem_we, mem_byteen});
`ifdef MEM_ERR_LATCH_EN
      chk("cmp_err_valid", 32'(err_valid), 32'(m_ev));
      if (m_ev) chk("cmp_err_addr", err_addr, m_ea);
`endif
    end
  end

  task automatic step(input bit req, input bit we, input logic [31:0] a, input logic [3:0] be,
                      input bit r, input bit clr);
    @(posedge clk);
    #1;
    rst        = r;
    mem_req    = req;
    mem_we     = we;
    mem_addr   = a;
    mem_byteen = be;
    mem_wdata  = ~a;
`ifdef MEM_ERR_LATCH_EN
    err_clr    = clr;
`else
    if (clr) mem_wdata = a;
`endif
  endtask

  initial begin
    resp_t idle;
    idle = '{v: 1'b0, e: 1'b0, d: 32'h0, a: 32'h0};
    exp_q.push_back(idle);
    // Request held during reset must be ignored.
    mem_req    = 1'b1;
    mem_addr   = 32'h0000_0010;
    mem_byteen = 4'hF;
    @(posedge clk);
    #1 ready = 1'b1;
    #1;
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_rvalid", 32'(mem_rvalid), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);

    step(1, 0, 32'h0000_0010, 4'hF, 0, 0); #2;
    chk("t1_sreq", 32'(s_req), 32'h1);
    chk("t0_no_resp", 32'(mem_rvalid), 32'h0);
    step(1, 0, 32'h1000_0004, 4'hF, 0, 0); #2;
    chk("t1_rvalid", 32'(mem_rvalid), 32'h1);
    chk("t1_err", 32'(mem_err), 32'h0);
    chk("t1_rdata", mem_rdata, 32'hA5A5_0010);
    chk("t2_sreq_rom", 32'(s_req), 32'h2);
    step(1, 0, 32'h0000_0008, 4'hF, 0, 0); #2;
    chk("t2_rom_rvalid", 32'(mem_rvalid), 32'h1);
    chk("t2_rom_rdata", mem_rdata, 32'h4A5A_0004);
    step(1, 1, 32'h1000_0000, 4'hF, 0, 0); #2;
    chk("t2_ram_rvalid", 32'(mem_rvalid), 32'h1);
    chk("t2_ram_rdata", mem_rdata, 32'hA5A5_0008);
    chk("t3_sreq", 32'(s_req), 32'h0);
    step(1, 1, 32'h0000_0020, 4'h3, 0, 0); #2;
    chk("t3_rvalid", 32'(mem_rvalid), 32'h1);
    chk("t3_err", 32'(mem_err), 32'h1);
    chk("t3_rdata", mem_rdata, 32'h0);
    chk("wr_sreq", 32'(s_req), 32'h1);
    step(1, 0, 32'h2000_0000, 4'hF, 0, 0); #2;
    chk("wr_err", 32'(mem_err), 32'h0);
    chk("wr_rdata", mem_rdata, 32'h0);
    chk("t4a_sreq", 32'(s_req), 32'h0);
    step(1, 0, 32'h0000_0002, 4'hF, 0, 0); #2;
    chk("t4a_err", 32'(mem_err), 32'h1);
    step(1, 0, 32'h0000_0000, 4'h0, 0, 0); #2;
    chk("t4b_err", 32'(mem_err), 32'h1);
    step(1, 0, 32'h0002_0000, 4'hF, 0, 0); #2;
    chk("t4c_err", 32'(mem_err), 32'h1);
    step(1, 0, 32'h1003_FFFC, 4'hF, 0, 0); #2;
    chk("t4d_err", 32'(mem_err), 32'h1);
    chk("rom_top_sreq", 32'(s_req), 32'h2);
    step(0, 0, 32'h0000_0004, 4'hF, 0, 0); #2;
    chk("rom_top_rdata", mem_rdata, 32'h4A59_FFFC);
    chk("idle_sreq", 32'(s_req), 32'h0);
    step(0, 0, 32'h0000_0004, 4'hF, 0, 0); #2;
    chk("idle_rvalid", 32'(mem_rvalid), 32'h0);

    step(1, 0, 32'h0000_0010, 4'hF, 0, 0);
    step(0, 0, 32'h0000_0000, 4'hF, 1, 0); #2;
    chk("t5_rvalid", 32'(mem_rvalid), 32'h0);
    chk("t5_rdata", mem_rdata, 32'h0);
    chk("t5_err", 32'(mem_err), 32'h0);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 0); #2;
    chk("t5_after_rvalid", 32'(mem_rvalid), 32'h0);

`ifdef MEM_ERR_LATCH_EN
    chk("t6_rst_valid", 32'(err_valid), 32'h0);
    step(1, 0, 32'h2000_0000, 4'hF, 0, 0);
    step(1, 0, 32'h3000_0000, 4'hF, 0, 0);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 0);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 0); #2;
    chk("t6_valid", 32'(err_valid), 32'h1);
    chk("t6_addr", err_addr, 32'h2000_0000);
    step(1, 0, 32'h4000_0000, 4'hF, 0, 0);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 1);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 0); #2;
    chk("t6_clr_race_valid", 32'(err_valid), 32'h1);
    chk("t6_clr_race_addr", err_addr, 32'h4000_0000);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 1);
    step(0, 0, 32'h0000_0000, 4'hF, 0, 0); #2;
    chk("t6_cleared", 32'(err_valid), 32'h0);
`endif

    repeat (2) step(0, 0, 32'h0, 4'h0, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
